// File: rtl/event_tx_scheduler_pkg.sv
// ----------------------------------------------------------------------------
// event_tx_scheduler_pkg
// Shared definitions for the SFIFO -> TX event scheduler:
//   - fixed event framing constants (header bytes, bytes per readout cell)
//   - 19-bit event length type (max 64 + 32 * 8191 = 262 176 bytes)
//   - scheduler state encoding
//   - helper that turns a readout depth into an event length
// ----------------------------------------------------------------------------
package event_tx_scheduler_pkg;

    // 32 common-FIFO header + 8x2 flag + 8x2 stop-cell bytes
    localparam int HDR_BYTES      = 64;
    // 8 FIFOs x 4 bytes per readout cell
    localparam int BYTES_PER_CELL = 32;

    localparam int LEN_W = 19;
    typedef logic [LEN_W-1:0] len_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2
    } state_e;

    // Event length in bytes for a given readout depth.
    function automatic len_t calc_evt_len(input logic [12:0] depth,
                                          input int          hdr,
                                          input int          bpc);
        return len_t'(hdr) + len_t'(bpc) * len_t'(depth);
    endfunction

endpackage

// File: rtl/event_tx_scheduler_if.sv
// ----------------------------------------------------------------------------
// event_tx_scheduler_if
// Bundles the SFIFO read side and the TCP transmit port seen by the scheduler.
//   master : the scheduler (drives SFIFO_RDEN, TX_DATA, TX_WE)
//   slave  : the FIFO / transmit environment
// Signals:
//   SFIFO_RDEN      read enable into the SFIFO
//   SFIFO_DOUT[7:0] SFIFO read data, valid with SFIFO_VALID
//   SFIFO_EMPTY     SFIFO empty
//   SFIFO_VALID     read data valid, one cycle after SFIFO_RDEN
//   SFIFO_WR_COUNT  SFIFO fill level (14 bits)
//   TX_AFULL        transmit almost-full (>= 3 free slots when asserted)
//   TX_DATA[7:0]    transmit byte
//   TX_WE           transmit write strobe
// ----------------------------------------------------------------------------
interface event_tx_scheduler_if;

    logic        SFIFO_RDEN;
    logic [7:0]  SFIFO_DOUT;
    logic        SFIFO_EMPTY;
    logic        SFIFO_VALID;
    logic [13:0] SFIFO_WR_COUNT;
    logic        TX_AFULL;
    logic [7:0]  TX_DATA;
    logic        TX_WE;

    modport master (
        output SFIFO_RDEN, TX_DATA, TX_WE,
        input  SFIFO_DOUT, SFIFO_EMPTY, SFIFO_VALID, SFIFO_WR_COUNT, TX_AFULL
    );

    modport slave (
        input  SFIFO_RDEN, TX_DATA, TX_WE,
        output SFIFO_DOUT, SFIFO_EMPTY, SFIFO_VALID, SFIFO_WR_COUNT, TX_AFULL
    );

endinterface

// File: rtl/event_tx_scheduler_stall_watchdog.sv
// ----------------------------------------------------------------------------
// stall_watchdog
// Generic stall counter: counts i_inc cycles, cleared by i_clr (clear wins).
// o_tc pulses on the increment that makes the TIMEOUT_CYC-th consecutive
// stall cycle, so a consumer registering o_tc reacts right after that cycle.
// The counter saturates at TIMEOUT_CYC until cleared.
// Ports:
//   CLK, RST  clock, asynchronous active-high reset
//   i_clr     clear the count
//   i_inc     count one stall cycle
//   o_tc      terminal count reached on this cycle
// ----------------------------------------------------------------------------
module stall_watchdog #(
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic CLK,
    input  logic RST,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_tc
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_at_max;

    assign w_at_max = (r_cnt == CNT_W'(TIMEOUT_CYC));
    assign o_tc     = i_inc && !i_clr && (r_cnt == CNT_W'(TIMEOUT_CYC - 1));

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && !w_at_max) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/event_tx_scheduler.sv
// ----------------------------------------------------------------------------
// event_tx_scheduler
// Read-side controller for the formatter output FIFO. Waits until enough
// event data is buffered, then moves exactly one event's bytes from the SFIFO
// to the transmit port, honouring TX_AFULL. Counts completed events and flags
// mid-event underrun stalls.
// Ports:
//   CLK, RST        clock, asynchronous active-high reset
//   ENABLE          permit starting new events (an event in flight completes)
//   DRS_READDEPTH   cells per channel, sampled when an event starts
//   bus             SFIFO read side + TX port (master modport)
//   BUSY            high outside IDLE
//   EVENT_COUNT     completed events, wraps
//   ERR_TIMEOUT     sticky stall error
//   ERR_CLR         clears ERR_TIMEOUT (a simultaneous timeout wins)
// ----------------------------------------------------------------------------
module event_tx_scheduler #(
    parameter int HDR_BYTES      = event_tx_scheduler_pkg::HDR_BYTES,
    parameter int BYTES_PER_CELL = event_tx_scheduler_pkg::BYTES_PER_CELL,
    parameter int START_THRESH   = 1024,
    parameter int TIMEOUT_CYC    = 65535
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic                        ENABLE,
    input  logic [12:0]                 DRS_READDEPTH,
    event_tx_scheduler_if.master        bus,
    output logic                        BUSY,
    output logic [31:0]                 EVENT_COUNT,
    output logic                        ERR_TIMEOUT,
    input  logic                        ERR_CLR
);

    import event_tx_scheduler_pkg::*;

    localparam logic [1:0] S_IDLE   = ST_IDLE;
    localparam logic [1:0] S_STREAM = ST_STREAM;
    localparam logic [1:0] S_DRAIN  = ST_DRAIN;

    logic [1:0]  r_state;
    len_t        r_len;
    len_t        r_rd_cnt;
    len_t        r_wr_cnt;
    logic        r_abort;
    logic [31:0] r_event_count;
    logic        r_err;
    logic [7:0]  r_tx_data;
    logic        r_tx_we;

    len_t        w_evt_len;
    len_t        w_start_thr;
    len_t        w_wr_cnt_nxt;
    logic        w_start;
    logic        w_more;
    logic        w_rden;
    logic        w_stall_inc;
    logic        w_timeout;
    logic        w_drained;

    // Length and threshold follow the live depth; only the length is latched.
    assign w_evt_len   = calc_evt_len(DRS_READDEPTH, HDR_BYTES, BYTES_PER_CELL);
    assign w_start_thr = (w_evt_len < len_t'(START_THRESH)) ? w_evt_len
                                                            : len_t'(START_THRESH);
    assign w_start     = (r_state == S_IDLE) && ENABLE &&
                         (len_t'(bus.SFIFO_WR_COUNT) >= w_start_thr);

    // Read enable is combinational so TX_AFULL stops reads in the same cycle;
    // only the two reads already in the FIFO/output register can still land.
    assign w_more      = (r_rd_cnt < r_len);
    assign w_rden      = (r_state == S_STREAM) && w_more &&
                         !bus.SFIFO_EMPTY && !bus.TX_AFULL;
    assign w_stall_inc = (r_state == S_STREAM) && w_more && bus.SFIFO_EMPTY;

    // Count the write happening this cycle so the event closes one cycle
    // after its last TX_WE rather than two.
    assign w_wr_cnt_nxt = r_wr_cnt + len_t'(r_tx_we);
    assign w_drained    = (w_wr_cnt_nxt == r_rd_cnt);

    stall_watchdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_stall_watchdog (
        .CLK   (CLK),
        .RST   (RST),
        .i_clr (w_rden || w_start),
        .i_inc (w_stall_inc),
        .o_tc  (w_timeout)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state       <= S_IDLE;
            r_len         <= '0;
            r_rd_cnt      <= '0;
            r_wr_cnt      <= '0;
            r_abort       <= 1'b0;
            r_event_count <= '0;
        end else begin
            if (r_tx_we) begin
                r_wr_cnt <= w_wr_cnt_nxt;
            end

            // NOTE: every case arm assigns state explicitly or holds it by
            // register semantics; the default arm recovers from illegal codes.
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_state  <= S_STREAM;
                        r_len    <= w_evt_len;
                        r_rd_cnt <= '0;
                        r_wr_cnt <= '0;
                        r_abort  <= 1'b0;
                    end
                end
                S_STREAM: begin
                    if (w_rden) begin
                        r_rd_cnt <= r_rd_cnt + len_t'(1);
                    end
                    if (w_timeout) begin
                        r_abort <= 1'b1;
                        r_state <= S_DRAIN;
                    end else if (!w_more) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (w_drained) begin
                        r_state <= S_IDLE;
                        if (!r_abort) begin
                            r_event_count <= r_event_count + 32'd1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Sticky error: a timeout in the same cycle as ERR_CLR keeps the flag set.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_err <= 1'b0;
        end else if (w_timeout) begin
            r_err <= 1'b1;
        end else if (ERR_CLR) begin
            r_err <= 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_tx_data <= '0;
            r_tx_we   <= 1'b0;
        end else begin
            r_tx_data <= bus.SFIFO_DOUT;
            r_tx_we   <= bus.SFIFO_VALID;
        end
    end

    assign bus.SFIFO_RDEN = w_rden;
    assign bus.TX_DATA    = r_tx_data;
    assign bus.TX_WE      = r_tx_we;
    assign BUSY           = (r_state != S_IDLE);
    assign EVENT_COUNT    = r_event_count;
    assign ERR_TIMEOUT    = r_err;

endmodule

// File: doc/event_tx_scheduler.md
# event_tx_scheduler

Read-side controller for the formatter output FIFO (SFIFO). It waits until enough formatted event data is buffered, then drains exactly one event's worth of bytes into the network transmit port, honouring transmit back-pressure. It counts completed events and flags underrun stalls. It sits between the data formatter and the TCP transmit interface, on the same CLK as the formatter's write side.

## Interface
Parameters:
- HDR_BYTES, 64: fixed bytes per event (32 common-FIFO header + 8×2 flag + 8×2 stop-cell).
- BYTES_PER_CELL, 32: data bytes per readout cell (8 FIFOs × 4 bytes).
- START_THRESH, 1024: maximum SFIFO fill required before streaming starts.
- TIMEOUT_CYC, 65535: empty-stall cycles mid-event before abort.

Ports:
- CLK  in  1  clock; also drives SFIFO_RDCLK externally.
- RST  in  1  asynchronous, active-high reset.
- ENABLE  in  1  permit starting new events.
- DRS_READDEPTH  in  13  cells per channel; sampled at event start.
- SFIFO_RDEN  out  1  SFIFO read enable.
- SFIFO_DOUT  in  8  SFIFO data.
- SFIFO_EMPTY  in  1  SFIFO empty.
- SFIFO_VALID  in  1  SFIFO data valid, one cycle after RDEN.
- SFIFO_WR_COUNT  in  14  SFIFO fill level.
- TX_AFULL  in  1  transmit almost-full; asserted with at least 3 free slots remaining.
- TX_DATA  out  8  transmit byte.
- TX_WE  out  1  transmit write strobe.
- BUSY  out  1  high outside IDLE.
- EVENT_COUNT  out  32  completed events, wraps.
- ERR_TIMEOUT  out  1  sticky stall error.
- ERR_CLR  in  1  clears ERR_TIMEOUT.

## Operation
- Event length: evt_len = HDR_BYTES + BYTES_PER_CELL × DRS_READDEPTH, computed in 19 bits (max 262 176). It is latched on leaving IDLE. DRS_READDEPTH changes mid-event are ignored.
- Start threshold: start_thr = min(evt_len, START_THRESH), evaluated combinationally from the live DRS_READDEPTH.
- **IDLE**: go to STREAM when ENABLE=1 and SFIFO_WR_COUNT ≥ start_thr. On the transition, latch len, clear rd_cnt, wr_cnt and stall_cnt.
- **STREAM**:
  - SFIFO_RDEN = ~SFIFO_EMPTY & ~TX_AFULL & (rd_cnt < len). This is combinational from the registered state; rd_cnt increments on each RDEN.
  - When rd_cnt reaches len, go to DRAIN.
  - stall_cnt increments on each cycle with SFIFO_EMPTY=1 and rd_cnt<len, and clears on any RDEN.
  - When stall_cnt reaches TIMEOUT_CYC: set ERR_TIMEOUT and go to DRAIN. No further reads; the partial event is not counted.
- **DRAIN**: wait until wr_cnt = rd_cnt, i.e. all issued reads have reached TX. Then increment EVENT_COUNT (unless aborted) and return to IDLE.
- Data path: TX_DATA <= SFIFO_DOUT and TX_WE <= SFIFO_VALID, registered. wr_cnt increments on TX_WE.
- ENABLE falling mid-event: the current event completes. It only blocks the next start.
- ERR_CLR and a timeout in the same cycle: set wins.
- EVENT_COUNT wraps from 2^32−1 to 0.

## Timing
- Reset values: SFIFO_RDEN=0, TX_DATA=0, TX_WE=0, BUSY=0, EVENT_COUNT=0, ERR_TIMEOUT=0, state=IDLE.
- RST mid-event clears everything immediately. Bytes still in SFIFO are not discarded by this block.
- IDLE→STREAM: 1 cycle after the threshold is met. The first RDEN comes in the first STREAM cycle.
- RDEN→TX_WE latency: 2 cycles (1 FIFO, 1 register).
- Throughput: 1 byte/cycle when TX_AFULL=0 and SFIFO is non-empty.
- TX_AFULL is honoured combinationally. At most 2 bytes remain in flight after it rises, which is why 3 slots of headroom are required.
- The last TX_WE of an event and the EVENT_COUNT increment are 1 cycle apart. BUSY falls with the return to IDLE.
- Back-to-back events: a new event starts no earlier than 1 cycle after returning to IDLE.

## Structure
- Shared package holds: the state enum (IDLE, STREAM, DRAIN), HDR_BYTES, BYTES_PER_CELL, and the 19-bit length type.
- One sub-module, `stall_watchdog`: a counter with clear, increment and terminal-count output at TIMEOUT_CYC. It is reused for future readout timeouts.

## Test plan
- DRS_READDEPTH=4, 192 bytes preloaded, TX_AFULL=0 → 192 TX_WE with data matching FIFO order; EVENT_COUNT=1; RDEN never exceeds 192.
- DRS_READDEPTH=1024 (evt_len 32 832 > START_THRESH), FIFO filled gradually → start at WR_COUNT=1024; exactly 32 832 bytes sent; EVENT_COUNT=1.
- TX_AFULL toggled randomly (20% duty) during a 192-byte event → no bytes lost or duplicated; at most 2 TX_WE after each TX_AFULL rise.
- FIFO goes empty after 100 of 192 bytes, TIMEOUT_CYC=50 → ERR_TIMEOUT=1 at stall cycle 50; 100 bytes sent; EVENT_COUNT unchanged; ERR_CLR clears the flag.
- ENABLE dropped at byte 50 with 2 events buffered → first event completes; second does not start until ENABLE returns.
- RST asserted at byte 80 → all outputs at reset values in the same cycle; after release, state is IDLE and EVENT_COUNT=0.
